arp_receiver: RTL and testbench

- Receive end of the radar azimuth reference pulse (ARP) link. The generator drives one ARP per antenna rotation (nominal 1 200 000 000 IN_CLK cycles = 12 s at 100 MHz).
- This block synchronises and debounces an incoming RADAR_ARP and emits a one-cycle ARP_PULSE per rotation.
- It measures the rotation period, qualifies it against a tolerance window, declares lock, and flags timeouts. Downstream azimuth and target-playback logic consume it.

---
 rtl/radar_sim_defs.sv | 20 ++
 rtl/arp_debounce.sv | 50 +++++
 rtl/arp_receiver.sv | 128 ++++++++++++
 tb/tb_arp_receiver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/radar_sim_defs.sv
// Shared radar-simulator definitions.
// Holds the ARP FSM state encodings, the nominal ARP period and tolerance
// (shared with the ARP generator so both ends agree) and a small saturating
// increment helper for 16-bit error counters.
package radar_sim_defs;

  // ARP receiver FSM states
  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] TRACK   = 2'd2;

  // One antenna rotation: 12 s at 100 MHz, +/- 1 %
  localparam int unsigned ARP_NOMINAL_PERIOD = 32'd1200000000;
  localparam int unsigned ARP_TOL            = 32'd12000000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arp_debounce.sv
// Synchroniser + debounce filter for a slow asynchronous pulse input.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   din   in   asynchronous input
//   level out  filtered level
//   rise  out  one-cycle strobe, registered alongside the 0->1 level change
// The filtered level flips only after DEBOUNCE consecutive synchronised
// samples differ from it; any sample equal to the level restarts the count.
module arp_debounce #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dcnt  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEBOUNCE - 1)) begin
        // This is the DEBOUNCE-th differing sample: commit the new level.
        level <= sync2;
        rise  <= sync2;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/arp_receiver.sv
// Receive end of the radar azimuth reference pulse (ARP) link.
// Debounces RADAR_ARP, emits one ARP_PULSE per rotation, measures the
// rotation period, qualifies it against an inclusive tolerance window,
// declares lock after LOCK_COUNT consecutive good periods and flags loss
// of ARP with a timeout strobe.
// Ports:
//   IN_CLK            in   100 MHz system clock
//   RST               in   synchronous active-high reset
//   RADAR_ARP         in   asynchronous ARP input
//   ARP_PULSE         out  one-cycle strobe per filtered rising edge
//   ARP_PERIOD        out  last measured period (cycles)
//   ARP_PERIOD_VALID  out  one-cycle strobe when ARP_PERIOD updates
//   ARP_LOCKED        out  high while tracking
//   ARP_TIMEOUT       out  one-cycle strobe on loss of ARP
//   ARP_ERR_CNT       out  saturating error count
module arp_receiver
  import radar_sim_defs::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned NOMINAL_PERIOD = ARP_NOMINAL_PERIOD,
  parameter int unsigned TOL            = ARP_TOL,
  parameter int unsigned DEBOUNCE       = 16,
  parameter int unsigned LOCK_COUNT     = 2
) (
  input  logic             IN_CLK,
  input  logic             RST,
  input  logic             RADAR_ARP,
  output logic             ARP_PULSE,
  output logic [CNT_W-1:0] ARP_PERIOD,
  output logic             ARP_PERIOD_VALID,
  output logic             ARP_LOCKED,
  output logic             ARP_TIMEOUT,
  output logic [15:0]      ARP_ERR_CNT
);

  localparam logic [CNT_W-1:0] WIN_MIN    = CNT_W'(NOMINAL_PERIOD - TOL);
  localparam logic [CNT_W-1:0] WIN_MAX    = CNT_W'(NOMINAL_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(NOMINAL_PERIOD + TOL + 1);
  localparam int unsigned      GW         = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0]    GOOD_LAST  = GW'(LOCK_COUNT - 1);

  logic             arp_rise;
  logic             arp_level_unused;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic [GW-1:0]    good_cnt;
  logic             in_win;

  arp_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk   (IN_CLK),
    .rst   (RST),
    .din   (RADAR_ARP),
    .level (arp_level_unused),
    .rise  (arp_rise)
  );

  always_comb begin
    in_win = (cnt >= WIN_MIN) && (cnt <= WIN_MAX);
  end

  always_ff @(posedge IN_CLK) begin
    if (RST) begin
      ARP_PULSE        <= 1'b0;
      ARP_PERIOD       <= '0;
      ARP_PERIOD_VALID <= 1'b0;
      ARP_LOCKED       <= 1'b0;
      ARP_TIMEOUT      <= 1'b0;
      ARP_ERR_CNT      <= '0;
      cnt              <= '0;
      state            <= SEARCH;
      good_cnt         <= '0;
    end else begin
      ARP_PULSE        <= arp_rise;
      ARP_PERIOD_VALID <= 1'b0;
      ARP_TIMEOUT      <= 1'b0;

      // Loading 1 on the edge makes cnt equal the edge-to-edge distance
      // when sampled at the following edge.
      if (arp_rise) begin
        cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        SEARCH: begin
          if (arp_rise) begin
            state <= MEASURE;
          end
        end
        MEASURE, TRACK: begin
          // Edge takes priority over timeout: an edge at TIMEOUT_AT is
          // simply an out-of-window period.
          if (arp_rise) begin
            ARP_PERIOD       <= cnt;
            ARP_PERIOD_VALID <= 1'b1;
            if (in_win) begin
              if (state == MEASURE) begin
                good_cnt <= good_cnt + GW'(1);
                if (good_cnt >= GOOD_LAST) begin
                  state      <= TRACK;
                  ARP_LOCKED <= 1'b1;
                end
              end
            end else begin
              ARP_ERR_CNT <= sat_inc16(ARP_ERR_CNT);
              ARP_LOCKED  <= 1'b0;
              good_cnt    <= '0;
              state       <= MEASURE;
            end
          end else if (cnt == TIMEOUT_AT) begin
            ARP_TIMEOUT <= 1'b1;
            ARP_ERR_CNT <= sat_inc16(ARP_ERR_CNT);
            ARP_LOCKED  <= 1'b0;
            good_cnt    <= '0;
            state       <= SEARCH;
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_receiver.sv
// Scoreboard bench for arp_receiver with NOMINAL_PERIOD=1000, TOL=10,
// DEBOUNCE=4, LOCK_COUNT=2. Stimulus pushes hand-computed output events
// (cycle, strobes, period, lock, error count); a negedge monitor pops and
// compares whenever the DUT raises ARP_PULSE, ARP_PERIOD_VALID or ARP_TIMEOUT.
module tb_arp_receiver;

  localparam int unsigned B = 20;

  logic        IN_CLK    = 1'b0;
  logic        RST       = 1'b1;
  logic        RADAR_ARP = 1'b0;
  logic        ARP_PULSE;
  logic [31:0] ARP_PERIOD;
  logic        ARP_PERIOD_VALID;
  logic        ARP_LOCKED;
  logic        ARP_TIMEOUT;
  logic [15:0] ARP_ERR_CNT;

  typedef struct {
    int unsigned cyc;
    bit          pulse;
    bit          valid;
    int unsigned period;
    bit          timeout;
    bit          locked;
    int unsigned err;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  bit          mon_ok;
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  arp_receiver #(
    .CNT_W          (32),
    .NOMINAL_PERIOD (1000),
    .TOL            (10),
    .DEBOUNCE       (4),
    .LOCK_COUNT     (2)
  ) dut (
    .IN_CLK           (IN_CLK),
    .RST              (RST),
    .RADAR_ARP        (RADAR_ARP),
    .ARP_PULSE        (ARP_PULSE),
    .ARP_PERIOD       (ARP_PERIOD),
    .ARP_PERIOD_VALID (ARP_PERIOD_VALID),
    .ARP_LOCKED       (ARP_LOCKED),
    .ARP_TIMEOUT      (ARP_TIMEOUT),
    .ARP_ERR_CNT      (ARP_ERR_CNT)
  );

  always #5 IN_CLK = ~IN_CLK;
  always @(posedge IN_CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: cyc=%0d, required finish before cycle %0d", cyc, B + 16500);
    $fatal(1, "watchdog expired");
  end

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge IN_CLK) begin
    if (!RST && (ARP_PULSE || ARP_PERIOD_VALID || ARP_TIMEOUT)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d pulse=%b valid=%b period=%0d timeout=%b locked=%b err=%0d, required no event",
                 cyc, ARP_PULSE, ARP_PERIOD_VALID, ARP_PERIOD, ARP_TIMEOUT, ARP_LOCKED, ARP_ERR_CNT);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (cyc == mon_e.cyc) && (ARP_PULSE == mon_e.pulse) &&
                 (ARP_PERIOD_VALID == mon_e.valid) && (ARP_TIMEOUT == mon_e.timeout) &&
                 (ARP_LOCKED == mon_e.locked) && (ARP_ERR_CNT == 16'(mon_e.err)) &&
                 (!mon_e.valid || ARP_PERIOD == mon_e.period);
        if (!mon_ok) begin
          errors++;
          $display("FAIL event: got cyc=%0d pulse=%b valid=%b period=%0d timeout=%b locked=%b err=%0d, required cyc=%0d pulse=%b valid=%b period=%0d timeout=%b locked=%b err=%0d",
                   cyc, ARP_PULSE, ARP_PERIOD_VALID, ARP_PERIOD, ARP_TIMEOUT, ARP_LOCKED, ARP_ERR_CNT,
                   mon_e.cyc, mon_e.pulse, mon_e.valid, mon_e.period, mon_e.timeout, mon_e.locked, mon_e.err);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (ARP_PULSE !== 1'b0 || ARP_PERIOD !== 32'd0 || ARP_PERIOD_VALID !== 1'b0 ||
        ARP_LOCKED !== 1'b0 || ARP_TIMEOUT !== 1'b0 || ARP_ERR_CNT !== 16'd0) begin
      errors++;
      $display("FAIL %s: got pulse=%b period=%0d valid=%b locked=%b timeout=%b err=%0d, required all 0",
               name, ARP_PULSE, ARP_PERIOD, ARP_PERIOD_VALID, ARP_LOCKED, ARP_TIMEOUT, ARP_ERR_CNT);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after posedge number c.
  task automatic wait_until(input int unsigned c);
    while (cyc < c) begin
      @(posedge IN_CLK);
      #1;
    end
  endtask

  task automatic push(input int unsigned c, input bit p, input bit v, input int unsigned per,
                      input bit t, input bit l, input int unsigned e);
    ev_t x;
    x.cyc = c; x.pulse = p; x.valid = v; x.period = per;
    x.timeout = t; x.locked = l; x.err = e;
    exp_q.push_back(x);
  endtask

  // Input rise at cycle c, high for hi cycles; pulse expected 7 cycles later.
  task automatic arp_in(input int unsigned c, input int unsigned hi, input bit v,
                        input int unsigned per, input bit l, input int unsigned e);
    push(c + 7, 1'b1, v, per, 1'b0, l, e);
    wait_until(c);
    RADAR_ARP = 1'b1;
    wait_until(c + hi);
    RADAR_ARP = 1'b0;
  endtask

  initial begin
    // Reset held 5 cycles with the input toggling
    for (int i = 0; i < 5; i++) begin
      @(posedge IN_CLK);
      #1;
      RADAR_ARP = ~RADAR_ARP;
      @(negedge IN_CLK);
      check_zero("reset_hold");
    end
    @(posedge IN_CLK);
    #1;
    RST       = 1'b0;
    RADAR_ARP = 1'b0;

    // Clean pulses every 1000 cycles: lock on the third edge
    arp_in(B,        50, 1'b0, 0,    1'b0, 0);
    arp_in(B + 1000, 50, 1'b1, 1000, 1'b0, 0);
    arp_in(B + 2000, 50, 1'b1, 1000, 1'b1, 0);

    // Glitches: 3 high, then 2 high / 1 low / 2 high -> nothing
    wait_until(B + 2200); RADAR_ARP = 1'b1;
    wait_until(B + 2203); RADAR_ARP = 1'b0;
    wait_until(B + 2300); RADAR_ARP = 1'b1;
    wait_until(B + 2302); RADAR_ARP = 1'b0;
    wait_until(B + 2303); RADAR_ARP = 1'b1;
    wait_until(B + 2305); RADAR_ARP = 1'b0;
    // Minimum-length clean pulse is accepted, still locked
    arp_in(B + 3000, 4, 1'b1, 1000, 1'b1, 0);

    // Period 1011 (one past window max) -> error, unlock; two 990s -> relock
    arp_in(B + 4011, 50, 1'b1, 1011, 1'b0, 1);
    arp_in(B + 5001, 50, 1'b1, 990,  1'b0, 1);
    arp_in(B + 5991, 50, 1'b1, 990,  1'b1, 1);

    // Pulses stop: timeout 1011 cycles after the last pulse, then SEARCH
    push(B + 5998 + 1011, 1'b0, 1'b0, 0, 1'b1, 1'b0, 2);
    arp_in(B + 7500, 50, 1'b0, 0,    1'b0, 2);
    arp_in(B + 8500, 50, 1'b1, 1000, 1'b0, 2);
    arp_in(B + 9500, 50, 1'b1, 1000, 1'b1, 2);

    // Edge landing exactly on the timeout cycle: error path, no timeout
    arp_in(B + 10511, 50, 1'b1, 1011, 1'b0, 3);
    // Left in MEASURE without edges: timeout fires from MEASURE too
    push(B + 10518 + 1011, 1'b0, 1'b0, 0, 1'b1, 1'b0, 4);
    arp_in(B + 12000, 50, 1'b0, 0,    1'b0, 4);
    arp_in(B + 13000, 50, 1'b1, 1000, 1'b0, 4);
    arp_in(B + 14000, 50, 1'b1, 1000, 1'b1, 4);

    // One-cycle reset mid-TRACK
    wait_until(B + 14300);
    RST = 1'b1;
    wait_until(B + 14301);
    RST = 1'b0;
    @(negedge IN_CLK);
    check_zero("reset_mid_track");
    @(posedge IN_CLK);
    #1;
    arp_in(B + 15000, 50, 1'b0, 0,    1'b0, 0);
    arp_in(B + 16000, 50, 1'b1, 1000, 1'b0, 0);

    wait_until(B + 16500);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen (first at cyc=%0d), required 0",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
